ifetch: RTL and testbench



---
 rtl/ifetch.sv | 107 ++++++++++
 tb/tb_ifetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: requests one word per instruction, holds it for decode
// until retired, then updates pc from the sequential, branch or jump target.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pcplus4,
  output logic [31:0] instret
);

  // state | meaning
  // IDLE  | one-cycle gap after reset, no request
  // FETCH | imem_req high, pc stable, waiting for imem_ack
  // HOLD  | instr valid for decode, waiting for instr_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;

  logic [31:0] branch_off;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;
  logic        retire;

  assign pcplus4    = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_tgt   = {pcplus4[31:28], instr_q[25:0], 2'b00};

  // jump takes priority over a simultaneously asserted branch select
  always_comb begin
    next_pc = pcplus4;
    if (jump) begin
      next_pc = jump_tgt;
    end else if (pcsrc) begin
      next_pc = pcplus4 + branch_off;
    end
  end

  assign retire = (state_q == S_HOLD) && instr_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      instret_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instret     = instret_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: sequential flow, branch/jump targets, stalls,
// address wrap from a high RESET_PC, and reset during an outstanding fetch.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic        jump;
  logic [31:0] pcplus4;
  logic [31:0] instret;

  logic        reset2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic [31:0] instr2;
  logic [5:0]  op2;
  logic [5:0]  funct2;
  logic        instr_valid2;
  logic        instr_ready2;
  logic [31:0] pcplus4_2;
  logic [31:0] instret2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ifetch u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .funct(funct), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pcsrc(pcsrc), .jump(jump), .pcplus4(pcplus4), .instret(instret)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instr(instr2), .op(op2),
    .funct(funct2), .instr_valid(instr_valid2), .instr_ready(instr_ready2),
    .pcsrc(1'b0), .jump(1'b0), .pcplus4(pcplus4_2), .instret(instret2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch+retire with same-cycle ack; pcsrc/jump are driven inverted
  // during FETCH to confirm they only matter at retire.
  task automatic step(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata,
                      input logic pcs, input logic jmp, input logic [31:0] exp_next);
    chk1({tag, "_req"}, imem_req, 1'b1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    chk1({tag, "_valid_fetch"}, instr_valid, 1'b0);
    imem_ack    = 1'b1;
    imem_rdata  = rdata;
    instr_ready = 1'b1;
    pcsrc       = ~pcs;
    jump        = ~jmp;
    tick();
    chk1({tag, "_valid_hold"}, instr_valid, 1'b1);
    chk1({tag, "_req_hold"}, imem_req, 1'b0);
    chk({tag, "_instr"}, instr, rdata);
    imem_ack = 1'b0;
    pcsrc    = pcs;
    jump     = jmp;
    tick();
    chk({tag, "_next"}, imem_addr, exp_next);
    instr_ready = 1'b0;
    pcsrc       = 1'b0;
    jump        = 1'b0;
  endtask

  initial begin
    reset = 1'b0;  imem_ack = 1'b0;  imem_rdata = 32'h0;
    instr_ready = 1'b0;  pcsrc = 1'b0;  jump = 1'b0;
    reset2 = 1'b0;  imem_ack2 = 1'b0;  imem_rdata2 = 32'h0;  instr_ready2 = 1'b0;
    #3;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pcplus4", pcplus4, 32'h4);
    tick();
    tick();
    reset = 1'b1;
    chk1("idle_req", imem_req, 1'b0);
    tick();
    chk1("first_req", imem_req, 1'b1);

    // sequential flow, every 2 cycles
    step("seq0", 32'h0, 32'h8C00_002A, 1'b0, 1'b0, 32'h4);
    chk("seq0_op", {26'h0, op}, 32'h23);
    chk("seq0_funct", {26'h0, funct}, 32'h2A);
    step("seq1", 32'h4, 32'h0000_0020, 1'b0, 1'b0, 32'h8);
    step("seq2", 32'h8, 32'h0000_0020, 1'b0, 1'b0, 32'hC);
    chk("seq_instret", instret, 32'd3);

    // branch taken / not taken from 0x10
    step("seqC", 32'hC, 32'h0000_0020, 1'b0, 1'b0, 32'h10);
    step("br_taken", 32'h10, 32'h1000_0003, 1'b1, 1'b0, 32'h20);
    step("jmp_back", 32'h20, 32'h0800_0004, 1'b0, 1'b1, 32'h10);
    step("br_nt", 32'h10, 32'h1000_0003, 1'b0, 1'b0, 32'h14);

    // jump wins over branch
    step("jmp40", 32'h14, 32'h0800_0010, 1'b0, 1'b1, 32'h40);
    step("jmp_pri", 32'h40, 32'h0800_0100, 1'b1, 1'b1, 32'h400);
    chk("pre_stall_instret", instret, 32'd9);

    // ack delayed 3 cycles, then ready low 4 cycles
    for (int i = 0; i < 3; i++) begin
      chk1("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, 32'h400);
      chk1("stall_valid", instr_valid, 1'b0);
      tick();
    end
    imem_ack = 1'b1;  imem_rdata = 32'h0800_0002;
    tick();
    imem_ack = 1'b1;  imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk1("hold_valid", instr_valid, 1'b1);
      chk1("hold_req", imem_req, 1'b0);
      chk("hold_instr", instr, 32'h0800_0002);
      chk("hold_addr", imem_addr, 32'h400);
      chk("hold_instret", instret, 32'd9);
      tick();
    end
    imem_ack = 1'b0;  instr_ready = 1'b1;  jump = 1'b1;
    tick();
    instr_ready = 1'b0;  jump = 1'b0;
    chk("stall_instret", instret, 32'd10);
    chk("stall_next", imem_addr, 32'h8);

    // negative branch offset returns to the same address
    step("br_neg", 32'h8, 32'h1000_FFFF, 1'b1, 1'b0, 32'h8);

    // reset asserted mid-FETCH, ack arrives after release
    chk1("pre_rst_req", imem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk1("async_rst_req", imem_req, 1'b0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_instret", instret, 32'h0);
    tick();
    reset = 1'b1;  imem_ack = 1'b1;  imem_rdata = 32'hDEAD_BEEF;
    chk1("late_ack_idle_req", imem_req, 1'b0);
    tick();
    imem_ack = 1'b0;
    chk1("refetch_req", imem_req, 1'b1);
    chk1("refetch_valid", instr_valid, 1'b0);
    chk("refetch_instr", instr, 32'h0);
    chk("refetch_addr", imem_addr, 32'h0);
    tick();
    chk1("refetch_still_valid", instr_valid, 1'b0);
    chk1("refetch_still_req", imem_req, 1'b1);

    // high RESET_PC wraps to zero
    reset2 = 1'b1;
    tick();
    chk1("hi_req", imem_req2, 1'b1);
    chk("hi_addr", imem_addr2, 32'hFFFF_FFFC);
    chk("hi_pcplus4", pcplus4_2, 32'h0);
    imem_ack2 = 1'b1;  imem_rdata2 = 32'h0000_0020;
    tick();
    imem_ack2 = 1'b0;  instr_ready2 = 1'b1;
    chk1("hi_valid", instr_valid2, 1'b1);
    tick();
    instr_ready2 = 1'b0;
    chk("hi_wrap_addr", imem_addr2, 32'h0);
    chk("hi_instret", instret2, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
